// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: owns the program counter, sequences fetches
// through the registered instruction memory and hands instructions to decode
// over a valid/ready handshake. Next address resolves jumps, return from
// interrupt and single-level vectored interrupts.
module fetch_sequencer #(
  parameter logic [3:0] VEC_BASE = 4'd12
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  pc,
  input  logic [15:0] instruction,
  output logic [15:0] instr_out,
  output logic [3:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_req,
  input  logic [3:0]  jump_addr,
  input  logic        reti,
  input  logic        irq,
  input  logic [1:0]  irq_vector,
  output logic        in_isr,
  output logic        irq_ack
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  pc_nx;
  logic [15:0] instr_out_nx;
  logic [3:0]  instr_pc_nx;
  logic        instr_valid_nx;
  logic [3:0]  saved_pc, saved_pc_nx;
  logic        in_isr_nx;
  logic        irq_ack_nx;

  // State and datapath registers; reset overrides any held instruction or ISR
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ISSUE;
      pc          <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      saved_pc    <= '0;
      in_isr      <= 1'b0;
      irq_ack     <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      instr_out   <= instr_out_nx;
      instr_pc    <= instr_pc_nx;
      instr_valid <= instr_valid_nx;
      saved_pc    <= saved_pc_nx;
      in_isr      <= in_isr_nx;
      irq_ack     <= irq_ack_nx;
    end
  end

  // Next-state and next-address resolution; everything holds unless updated
  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    instr_out_nx   = instr_out;
    instr_pc_nx    = instr_pc;
    instr_valid_nx = instr_valid;
    saved_pc_nx    = saved_pc;
    in_isr_nx      = in_isr;
    irq_ack_nx     = 1'b0;
    case (state)
      ISSUE: state_nx = WAIT;
      WAIT: begin
        instr_out_nx   = instruction;
        instr_pc_nx    = pc;
        instr_valid_nx = 1'b1;
        state_nx       = VALID;
      end
      VALID: begin
        if (instr_ready) begin
          instr_valid_nx = 1'b0;
          state_nx       = ISSUE;
          if (jump_req) begin
            pc_nx = jump_addr;
          end else if (reti && in_isr) begin
            pc_nx     = saved_pc;
            in_isr_nx = 1'b0;
          end else if (irq && !in_isr) begin
            saved_pc_nx = instr_pc + 4'd1;
            pc_nx       = VEC_BASE + {2'b00, irq_vector};
            in_isr_nx   = 1'b1;
            irq_ack_nx  = 1'b1;
          end else begin
            pc_nx = instr_pc + 4'd1;
          end
        end
      end
      default: state_nx = ISSUE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a transaction-level model tracks
// which address each delivered instruction must come from, the ISR flag and
// the return address, and every handshake is compared against it.
module tb_fetch_sequencer;

  localparam logic [3:0] VEC = 4'd12;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pc;
  logic [15:0] instruction;
  logic [15:0] instr_out;
  logic [3:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_req;
  logic [3:0]  jump_addr;
  logic        reti;
  logic        irq;
  logic [1:0]  irq_vector;
  logic        in_isr;
  logic        irq_ack;

  fetch_sequencer #(.VEC_BASE(VEC)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_req(jump_req), .jump_addr(jump_addr),
    .reti(reti), .irq(irq), .irq_vector(irq_vector), .in_isr(in_isr),
    .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  // Registered instruction memory
  logic [15:0] mem [16];
  always @(posedge clk) instruction <= mem[pc];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] m_pc;
  logic [3:0] m_saved;
  bit         m_isr;
  bit         m_ack;

  task automatic scramble();
    instr_ready = 1'($urandom);
    jump_req    = 1'($urandom);
    jump_addr   = 4'($urandom);
    reti        = 1'($urandom);
    irq         = 1'($urandom);
    irq_vector  = 2'($urandom);
  endtask

  task automatic model_reset();
    m_pc = '0; m_saved = '0; m_isr = 0; m_ack = 0;
  endtask

  // One fetch: wait for delivery, optional stall, then handshake with controls
  task automatic step(input int stall, input bit j, input logic [3:0] ja,
                      input bit r, input bit i, input logic [1:0] v);
    int cnt;
    logic [15:0] h_out;
    logic [3:0]  h_ipc, h_pc, vv;
    checks++;
    if (pc !== m_pc) begin
      errors++; $display("FAIL issue_pc: got %0d expected %0d", pc, m_pc);
    end
    checks++;
    if (irq_ack !== m_ack) begin
      errors++; $display("FAIL irq_ack_after_hs: got %0b expected %0b", irq_ack, m_ack);
    end
    checks++;
    if (in_isr !== m_isr) begin
      errors++; $display("FAIL in_isr_issue: got %0b expected %0b", in_isr, m_isr);
    end
    cnt = 0;
    while (instr_valid !== 1'b1 && cnt < 10) begin
      scramble();
      @(negedge clk);
      cnt++;
      checks++;
      if (irq_ack !== 1'b0) begin
        errors++; $display("FAIL irq_ack_not_pulse: got %0b expected 0", irq_ack);
      end
    end
    checks++;
    if (cnt != 2) begin
      errors++; $display("FAIL fetch_latency: got %0d edges expected 2", cnt);
    end
    checks++;
    if (instr_pc !== m_pc || instr_out !== mem[m_pc]) begin
      errors++;
      $display("FAIL deliver: got pc=%0d instr=%h expected pc=%0d instr=%h",
               instr_pc, instr_out, m_pc, mem[m_pc]);
    end
    h_out = instr_out; h_ipc = instr_pc; h_pc = pc;
    for (int s = 0; s < stall; s++) begin
      scramble();
      instr_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== h_out || instr_pc !== h_ipc ||
          pc !== h_pc || irq_ack !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got v=%0b out=%h ipc=%0d pc=%0d ack=%0b expected v=1 out=%h ipc=%0d pc=%0d ack=0",
                 instr_valid, instr_out, instr_pc, pc, irq_ack, h_out, h_ipc, h_pc);
      end
    end
    instr_ready = 1'b1;
    jump_req = j; jump_addr = ja; reti = r; irq = i; irq_vector = v;
    @(negedge clk);
    m_ack = 0;
    if (j) begin
      m_pc = ja;
    end else if (r && m_isr) begin
      m_pc = m_saved; m_isr = 0;
    end else if (i && !m_isr) begin
      m_saved = m_pc + 4'd1;
      vv = {2'b00, v};
      m_pc = VEC + vv;
      m_isr = 1; m_ack = 1;
    end else begin
      m_pc = m_pc + 4'd1;
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL valid_drop: got %0b expected 0", instr_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scramble();
    repeat (3) @(negedge clk);
    checks++;
    if (pc !== 4'd0 || instr_out !== 16'd0 || instr_pc !== 4'd0 ||
        instr_valid !== 1'b0 || in_isr !== 1'b0 || irq_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got pc=%0d out=%h ipc=%0d v=%0b isr=%0b ack=%0b expected all zero",
               pc, instr_out, instr_pc, instr_valid, in_isr, irq_ack);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    step(0, 0, 4'd0, 0, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
  endtask

  task automatic test_backpressure();
    test_reset();
    step(0, 0, 4'd0, 0, 0, 2'd0);
    step(5, 0, 4'd0, 0, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
  endtask

  task automatic test_jump_wrap();
    step(0, 1, 4'd14, 0, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
  endtask

  task automatic test_irq();
    step(1, 0, 4'd0, 0, 1, 2'd1);
    step(0, 0, 4'd0, 0, 1, 2'd2);
    step(0, 0, 4'd0, 1, 1, 2'd1);
    step(0, 0, 4'd0, 0, 1, 2'd1);
    step(2, 0, 4'd0, 1, 0, 2'd0);
  endtask

  task automatic test_jump_irq();
    step(0, 1, 4'd8, 0, 1, 2'd1);
    step(0, 0, 4'd0, 0, 1, 2'd2);
    step(0, 1, 4'd3, 0, 0, 2'd0);
    step(0, 0, 4'd0, 1, 0, 2'd0);
    step(0, 0, 4'd0, 1, 0, 2'd0);
  endtask

  task automatic test_reset_mid();
    int cnt;
    step(0, 0, 4'd0, 0, 1, 2'd3);
    cnt = 0;
    while (instr_valid !== 1'b1 && cnt < 10) begin
      instr_ready = 1'b0;
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (instr_valid !== 1'b1 || in_isr !== 1'b1) begin
      errors++; $display("FAIL isr_valid_before_reset: got v=%0b isr=%0b expected 1 1", instr_valid, in_isr);
    end
    rst = 1'b1; instr_ready = 1'b1; irq = 1'b1;
    @(negedge clk);
    checks++;
    if (pc !== 4'd0 || instr_out !== 16'd0 || instr_pc !== 4'd0 ||
        instr_valid !== 1'b0 || in_isr !== 1'b0 || irq_ack !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got pc=%0d out=%h ipc=%0d v=%0b isr=%0b ack=%0b expected all zero",
               pc, instr_out, instr_pc, instr_valid, in_isr, irq_ack);
    end
    rst = 1'b0;
    model_reset();
    step(0, 0, 4'd0, 1, 0, 2'd0);
    step(0, 0, 4'd0, 0, 0, 2'd0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      step(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 4'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 2'($urandom));
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 16'($urandom);
    mem[0] = 16'h2001; mem[1] = 16'h2101; mem[2] = 16'h2201; mem[13] = 16'h8001;
    rst = 1'b1;
    scramble();
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump_wrap();
    test_irq();
    test_jump_irq();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
